// File: rtl/serial_sub_8.sv
// Bit-serial, LSB-first subtractor: {bout, d} = a - b - bin over WIDTH cycles.
// One registered borrow flop replaces the combinational borrow chain.
module serial_sub_8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             diff;
  logic             brw_nxt;
  logic [WIDTH-1:0] sr_shift;

  always_comb begin
    diff     = sa_q[0] ^ sb_q[0] ^ brw_q;
    brw_nxt  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & brw_q);
    sr_shift = {diff, sr_q[WIDTH-1:1]};

    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          brw_d   = bin;
          sr_d    = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        brw_d = brw_nxt;
        sr_d  = sr_shift;
        cnt_d = cnt_q + CW'(1);
        // Final bit: publish result directly from the shift input so d never sees partials.
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = sr_shift;
          bout_d  = brw_nxt;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_8.sv
// Directed + random bench for serial_sub_8 with a queue-based result scoreboard.
module tb_serial_sub_8;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, bin;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, bout;
  logic [WIDTH-1:0] d;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0] sb_q[$];

  always #5 clk = ~clk;

  serial_sub_8 #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .d    (d),
    .bout (bout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive operands with start high and push the reference result.
  task automatic drive_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic binv);
    a     = av;
    b     = bv;
    bin   = binv;
    start = 1'b1;
    sb_q.push_back({1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, binv});
  endtask

  // Called at the negedge where start was raised; returns at the negedge where done is seen.
  // poke_at > 0 raises start with junk operands for one edge at that negedge.
  task automatic wait_done(input bit hold, input int poke_at,
                           output int lat, output int busy_cnt, output bit moved);
    logic [WIDTH:0] entry;
    entry    = {bout, d};
    lat      = 0;
    busy_cnt = 0;
    moved    = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !hold) start = 1'b0;
      if (poke_at > 0 && lat == poke_at) begin
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
      end
      if (poke_at > 0 && lat == poke_at + 1) start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done !== 1'b1 && {bout, d} !== entry) moved = 1'b1;
    end while (done !== 1'b1 && lat < 4 * WIDTH);
  endtask

  task automatic check_result(input string tag);
    logic [WIDTH:0] exp;
    check({tag, "_sb_nonempty"}, (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_d"}, 32'(d), 32'(exp[WIDTH-1:0]));
      check({tag, "_bout"}, 32'(bout), 32'(exp[WIDTH]));
    end
  endtask

  initial begin
    int lat, bcnt, pulses;
    bit moved;
    logic [WIDTH-1:0] va[3];
    logic [WIDTH-1:0] vb[3];
    logic             vc[3];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst_n = 1'b1;

    // Basic operation with latency and busy-window checks
    @(negedge clk);
    drive_op(8'h5A, 8'h3C, 1'b0);
    wait_done(1'b0, 0, lat, bcnt, moved);
    check("t1_latency", 32'(lat), 32'(WIDTH + 1));
    check("t1_busy_cycles", 32'(bcnt), 32'(WIDTH));
    check("t1_busy_at_done", 32'(busy), 32'd0);
    check_result("t1");
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_d_hold", 32'(d), 32'h1E);

    // Boundary operands
    va = '{8'h00, 8'h80, 8'hFF};
    vb = '{8'h01, 8'h7F, 8'hFF};
    vc = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_op(va[i], vb[i], vc[i]);
      wait_done(1'b0, 0, lat, bcnt, moved);
      check("t2_latency", 32'(lat), 32'(WIDTH + 1));
      check_result("t2");
    end
    @(negedge clk);

    // Back-to-back with start held high
    drive_op(8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b1, 0, lat, bcnt, moved);
      check("b2b_latency", 32'(lat), 32'(WIDTH + 1));
      check("b2b_busy_cycles", 32'(bcnt), 32'(WIDTH));
      check("b2b_d_held", 32'(moved), 32'd0);
      check_result("b2b");
      if (i < 3) drive_op(8'(8'h21 * (i + 3)), 8'(8'h47 * (i + 1)), 1'(i));
      else start = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_done", 32'(done), 32'd0);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // start pulsed mid-RUN at count=3 must be ignored
    drive_op(8'h33, 8'h44, 1'b1);
    wait_done(1'b0, 4, lat, bcnt, moved);
    check("midstart_latency", 32'(lat), 32'(WIDTH + 1));
    check_result("midstart");
    @(negedge clk);
    check("midstart_no_restart", 32'(busy), 32'd0);

    // Reset mid-RUN at count=4 aborts without a done pulse
    drive_op(8'hC3, 8'h5D, 1'b0);
    void'(sb_q.pop_back());
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    drive_op(8'h10, 8'h01, 1'b0);
    wait_done(1'b0, 0, lat, bcnt, moved);
    check("post_abort_latency", 32'(lat), 32'(WIDTH + 1));
    check_result("post_abort");
    @(negedge clk);

    // Reset and start on the same edge: reset wins
    rst_n = 1'b0; start = 1'b1; a = 8'h77; b = 8'h11; bin = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_start_idle", 32'(busy), 32'd0);

    // Random regression, mixing IDLE and DONE acceptance
    for (int i = 0; i < 1000; i++) begin
      drive_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_done(1'b0, 0, lat, bcnt, moved);
      check("rnd_latency", 32'(lat), 32'(WIDTH + 1));
      check_result("rnd");
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
